// File: rtl/wm_embed_ctrl_pkg.sv
// Shared definitions for the watermark embed controller.
// Provides the FSM state enum, the cell KEY mode codes and the chunk width.
package wm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    ARM     = 3'd2,
    EMBED   = 3'd3,
    SEAL    = 3'd4,
    RELEASE = 3'd5
  } state_e;

  localparam logic [1:0] KEY_OFF   = 2'b00;
  localparam logic [1:0] KEY_EMBED = 2'b01;
  localparam int         CHUNK_W   = 3;

endpackage

// File: rtl/wm_embed_ctrl_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req     : level requests from requester 0 (bit 0) and requester 1 (bit 1)
//   ptr     : index of the requester granted last
//   gnt_nxt : one-hot grant to apply on the next edge, 2'b00 if no request
module rr_arb2
  import wm_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt_nxt
);

  // A lone request wins outright; on a tie the requester not served last wins.
  always_comb begin
    gnt_nxt = 2'b00;
    case (req)
      2'b01:   gnt_nxt = 2'b01;
      2'b10:   gnt_nxt = 2'b10;
      2'b11:   gnt_nxt = ptr ? 2'b01 : 2'b10;
      default: gnt_nxt = 2'b00;
    endcase
  end

endmodule

// File: rtl/wm_embed_ctrl.sv
// Sequencer/arbiter in front of one watermark protection cell.
// Grants one of two requesters, embeds a WM_BITS watermark into the cell
// three bits per PHASES-cycle window, reads back RGZ per window into SIG and
// flags a mismatch (or an aborted job) on ERR together with the DONE pulse.
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   REQ, DIN0, DIN1 : requests and payloads of the two requesters
//   WM              : watermark word, sampled in GRANT
//   GNT, BUSY       : one-hot grant, not-idle status
//   DONE, ERR, SIG  : completion pulse, error flag, captured signature
//   PRST, KEY, ENA  : protection-cell reset, mode, enable
//   RGA, RGB, RGZ   : cell data inputs (chunk, payload) and cell output
module wm_embed_ctrl
  import wm_pkg::*;
#(
  parameter int WM_BITS = 12,
  parameter int PHASES  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [1:0]         REQ,
  input  logic [7:0]         DIN0,
  input  logic [7:0]         DIN1,
  input  logic [WM_BITS-1:0] WM,
  output logic [1:0]         GNT,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic [WM_BITS-1:0] SIG,
  output logic               PRST,
  output logic [1:0]         KEY,
  output logic               ENA,
  output logic [7:0]         RGA,
  output logic [7:0]         RGB,
  input  logic [7:0]         RGZ
);

  localparam int NCHUNK = WM_BITS / CHUNK_W;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam int PW     = $clog2(PHASES);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);

  if (WM_BITS % CHUNK_W != 0) begin : g_bad_wm_bits
    $error("wm_embed_ctrl: WM_BITS must be a multiple of 3");
  end
  if (PHASES != 4) begin : g_bad_phases
    $error("wm_embed_ctrl: PHASES must match the 4-cycle cell phase period");
  end

  state_e             state_q;
  logic [1:0]         gnt_q;
  logic               win_q;
  logic               ptr_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [WM_BITS-1:0] sig_q;
  logic [WM_BITS-1:0] wm_q;
  logic [WM_BITS-1:0] sr_q;
  logic [1:0]         key_q;
  logic               ena_q;
  logic [CW-1:0]      chunk_q;
  logic [PW-1:0]      phase_q;

  logic [1:0] gnt_nxt_s;
  logic       abort_s;
  logic       unused_rgz_s;

  rr_arb2 u_arb (
    .req     (REQ),
    .ptr     (ptr_q),
    .gnt_nxt (gnt_nxt_s)
  );

  // The job is abandoned as soon as the granted requester lets go of REQ.
  assign abort_s      = ~|(REQ & gnt_q);
  // Only the low chunk of the cell output carries signature bits.
  assign unused_rgz_s = ^RGZ[7:CHUNK_W];

  // Job sequencer: state, counters, shift register, signature and outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      win_q   <= 1'b0;
      ptr_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sig_q   <= '0;
      wm_q    <= '0;
      sr_q    <= '0;
      key_q   <= KEY_OFF;
      ena_q   <= 1'b0;
      chunk_q <= '0;
      phase_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|gnt_nxt_s) begin
            state_q <= GRANT;
            gnt_q   <= gnt_nxt_s;
            win_q   <= gnt_nxt_s[1];
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          wm_q    <= WM;
          sr_q    <= WM;
          sig_q   <= '0;
          chunk_q <= '0;
          phase_q <= '0;
          state_q <= ARM;
        end
        ARM, EMBED, SEAL: begin
          if (abort_s) begin
            state_q <= RELEASE;
            gnt_q   <= 2'b00;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            key_q   <= KEY_OFF;
            ena_q   <= 1'b0;
          end else if (state_q == ARM) begin
            state_q <= EMBED;
            key_q   <= KEY_EMBED;
            ena_q   <= 1'b1;
          end else if (state_q == EMBED) begin
            phase_q <= (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
            // End of a window: the cell output now reflects the current chunk.
            if (phase_q == LAST_PHASE) begin
              sig_q   <= {sig_q[WM_BITS-CHUNK_W-1:0], RGZ[CHUNK_W-1:0]};
              sr_q    <= {sr_q[WM_BITS-CHUNK_W-1:0], {CHUNK_W{1'b0}}};
              chunk_q <= chunk_q + CW'(1);
              if (chunk_q == LAST_CHUNK) begin
                state_q <= SEAL;
                ena_q   <= 1'b0;
              end
            end
          end else begin
            state_q <= RELEASE;
            gnt_q   <= 2'b00;
            done_q  <= 1'b1;
            err_q   <= (sig_q != wm_q);
            key_q   <= KEY_OFF;
          end
        end
        RELEASE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ptr_q   <= win_q;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          key_q   <= KEY_OFF;
          ena_q   <= 1'b0;
        end
      endcase
    end
  end

  assign GNT  = gnt_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;
  assign SIG  = sig_q;
  assign KEY  = key_q;
  assign ENA  = ena_q;
  // The cell is held in reset by RST itself and cleared again during ARM.
  assign PRST = RST | (state_q == ARM);
  // ENA is high exactly during EMBED; the payload follows DIN combinationally.
  assign RGA  = ena_q ? {{(8-CHUNK_W){1'b0}}, sr_q[WM_BITS-1 -: CHUNK_W]} : 8'h00;
  assign RGB  = ena_q ? (win_q ? DIN1 : DIN0) : 8'h00;

endmodule

// File: tb/tb_wm_embed_ctrl.sv
// Directed self-checking bench for wm_embed_ctrl with a behavioural cell model.
module tb_wm_embed_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  REQ = 2'b00;
  logic [7:0]  DIN0 = 8'h00;
  logic [7:0]  DIN1 = 8'h00;
  logic [11:0] WM = 12'h000;
  logic [1:0]  GNT;
  logic        BUSY, DONE, ERR, PRST, ENA;
  logic [11:0] SIG;
  logic [1:0]  KEY;
  logic [7:0]  RGA, RGB, RGZ;

  logic [7:0]  cell_q = 8'h00;
  logic        cell_force0 = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc;
  logic [2:0] chunks [4];
  logic [7:0] exp_v;

  wm_embed_ctrl #(.WM_BITS(12), .PHASES(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DIN0(DIN0), .DIN1(DIN1), .WM(WM),
    .GNT(GNT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .SIG(SIG),
    .PRST(PRST), .KEY(KEY), .ENA(ENA), .RGA(RGA), .RGB(RGB), .RGZ(RGZ)
  );

  always #5 CLK = ~CLK;

  // Cell model: echoes RGA while embedding, cleared by PRST.
  always @(posedge CLK) begin
    if (PRST) cell_q <= 8'h00;
    else if (ENA && KEY == 2'b01) cell_q <= RGA;
  end
  assign RGZ = cell_force0 ? {cell_q[7:3], 3'b000} : cell_q;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (DONE !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
    check("done_seen", {31'd0, DONE}, 32'd1);
  endtask

  initial begin
    chunks[0] = 3'd5; chunks[1] = 3'd1; chunks[2] = 3'd3; chunks[3] = 3'd4;

    // Reset
    tick(); tick();
    check("prst_in_rst", {31'd0, PRST}, 32'd1);
    check("rst_gnt",  {30'd0, GNT}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_sig",  {20'd0, SIG}, 32'd0);
    check("rst_key",  {30'd0, KEY}, 32'd0);
    check("rst_rga",  {24'd0, RGA}, 32'd0);
    RST = 1'b0;
    tick();
    check("idle_prst", {31'd0, PRST}, 32'd0);

    // Job 1: requester 0, WM=A5C -> chunks 5,1,3,4
    REQ = 2'b01; WM = 12'hA5C; DIN0 = 8'h3C; DIN1 = 8'hC3;
    tick();
    check("j1_gnt", {30'd0, GNT}, 32'h1);
    check("j1_busy", {31'd0, BUSY}, 32'd1);
    tick();
    check("j1_arm_prst", {31'd0, PRST}, 32'd1);
    check("j1_arm_ena", {31'd0, ENA}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("j1_rga", {24'd0, RGA}, {29'd0, chunks[i/4]});
      if (i == 0) begin
        check("j1_key", {30'd0, KEY}, 32'h1);
        check("j1_rgb", {24'd0, RGB}, 32'h3C);
      end
    end
    tick();
    check("j1_seal_key", {30'd0, KEY}, 32'h1);
    check("j1_seal_ena", {31'd0, ENA}, 32'd0);
    check("j1_seal_gnt", {30'd0, GNT}, 32'h1);
    tick();
    check("j1_done", {31'd0, DONE}, 32'd1);
    check("j1_err", {31'd0, ERR}, 32'd0);
    check("j1_sig", {20'd0, SIG}, 32'hA5C);
    check("j1_rel_gnt", {30'd0, GNT}, 32'd0);
    check("j1_rel_key", {30'd0, KEY}, 32'd0);
    REQ = 2'b00;
    tick();
    check("j1_done_pulse", {31'd0, DONE}, 32'd0);
    check("j1_idle_busy", {31'd0, BUSY}, 32'd0);
    check("j1_sig_hold", {20'd0, SIG}, 32'hA5C);

    // Round-robin: reset, then REQ=11 twice
    RST = 1'b1; tick(); RST = 1'b0; tick();
    REQ = 2'b11; WM = 12'h6B3;
    tick();
    check("rr1_gnt", {30'd0, GNT}, 32'h1);
    wait_done(40, cyc);
    check("rr1_latency", cyc, 32'd19);
    check("rr1_err", {31'd0, ERR}, 32'd0);
    check("rr1_sig", {20'd0, SIG}, 32'h6B3);
    tick();
    check("rr_gap_gnt", {30'd0, GNT}, 32'd0);
    check("rr_gap_busy", {31'd0, BUSY}, 32'd0);
    tick();
    check("rr2_gnt", {30'd0, GNT}, 32'h2);
    wait_done(40, cyc);
    check("rr2_err", {31'd0, ERR}, 32'd0);
    REQ = 2'b00;
    tick();

    // Signature mismatch: cell output forced to zero
    cell_force0 = 1'b1; WM = 12'h001; REQ = 2'b01;
    tick();
    check("mm_gnt", {30'd0, GNT}, 32'h1);
    wait_done(40, cyc);
    check("mm_err", {31'd0, ERR}, 32'd1);
    check("mm_sig", {20'd0, SIG}, 32'h000);
    REQ = 2'b00; cell_force0 = 1'b0;
    tick();

    // Abort at third EMBED cycle
    REQ = 2'b01; WM = 12'hFFF;
    tick(); tick(); tick(); tick(); tick();
    check("ab_embed_ena", {31'd0, ENA}, 32'd1);
    REQ = 2'b00;
    tick();
    check("ab_done", {31'd0, DONE}, 32'd1);
    check("ab_err", {31'd0, ERR}, 32'd1);
    check("ab_gnt", {30'd0, GNT}, 32'd0);
    check("ab_key", {30'd0, KEY}, 32'd0);
    tick();
    check("ab_done_pulse", {31'd0, DONE}, 32'd0);
    check("ab_idle_busy", {31'd0, BUSY}, 32'd0);

    // Reset mid-EMBED
    REQ = 2'b01; WM = 12'h123;
    tick(); tick(); tick(); tick();
    check("rm_embed_ena", {31'd0, ENA}, 32'd1);
    RST = 1'b1; REQ = 2'b00;
    #1;
    check("rm_prst_now", {31'd0, PRST}, 32'd1);
    tick();
    check("rm_gnt", {30'd0, GNT}, 32'd0);
    check("rm_busy", {31'd0, BUSY}, 32'd0);
    check("rm_done", {31'd0, DONE}, 32'd0);
    check("rm_sig", {20'd0, SIG}, 32'd0);
    check("rm_key", {30'd0, KEY}, 32'd0);
    check("rm_ena", {31'd0, ENA}, 32'd0);
    check("rm_rgb", {24'd0, RGB}, 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rm_no_done", {31'd0, DONE}, 32'd0);
    end

    // Requester 1 job with DIN1 changing every cycle
    REQ = 2'b10; WM = 12'h5A5; DIN0 = 8'hEE;
    tick();
    check("d1_gnt", {30'd0, GNT}, 32'h2);
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_v = 8'h01 + 8'(i);
      DIN1 = exp_v;
      #1;
      check("d1_rgb", {24'd0, RGB}, {24'd0, exp_v});
    end
    wait_done(10, cyc);
    check("d1_err", {31'd0, ERR}, 32'd0);
    check("d1_sig", {20'd0, SIG}, 32'h5A5);
    REQ = 2'b00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
